// File: rtl/cache_types_pkg.sv
// Shared constants and FSM state type for the cacheline <-> memory-burst adapter.
package cache_types_pkg;

  localparam int unsigned s_offset  = 5;
  localparam int unsigned s_line    = 256;
  localparam int unsigned s_burst   = 64;
  localparam int unsigned num_beats = s_line / s_burst;
  localparam int unsigned beat_w    = (num_beats > 1) ? $clog2(num_beats) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } cla_state_t;

endpackage

// File: rtl/cla_line_buffer.sv
// Line-wide register with whole-line load, per-beat write (read assembly)
// and beat-indexed read mux (write disassembly).
module cla_line_buffer #(
  parameter int unsigned s_line  = 256,
  parameter int unsigned s_burst = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [s_line-1:0]           line_in,
  input  logic                        beat_we,
  input  logic [$clog2(s_line/s_burst > 1 ? s_line/s_burst : 2)-1:0] beat_idx,
  input  logic [s_burst-1:0]          beat_in,
  output logic [s_line-1:0]           line,
  output logic [s_burst-1:0]          beat_out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
    end else if (load) begin
      line <= line_in;
    end else if (beat_we) begin
      line[int'(beat_idx) * s_burst +: s_burst] <= beat_in;
    end
  end

  assign beat_out = line[int'(beat_idx) * s_burst +: s_burst];

endmodule

// File: rtl/new_cacheline_adapter.sv
// Cache-line to fixed-length memory burst adapter (read fill and writeback).
// Optional per-direction completed-line counters when CLA_PERF_CNT_EN is defined.
module new_cacheline_adapter
  import cache_types_pkg::*;
#(
  parameter int unsigned s_offset = cache_types_pkg::s_offset,
  parameter int unsigned s_line   = cache_types_pkg::s_line,
  parameter int unsigned s_burst  = cache_types_pkg::s_burst
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
`ifdef CLA_PERF_CNT_EN
  ,
  output logic [31:0]        rd_lines_o,
  output logic [31:0]        wr_lines_o
`endif
);

  localparam int unsigned nbeats = s_line / s_burst;
  localparam int unsigned bw     = (nbeats > 1) ? $clog2(nbeats) : 1;

  cla_state_t            state;
  logic [bw-1:0]         beat;
  logic                  last_beat;
  logic [31:0]           aligned_addr;
  logic                  wr_load;
  logic                  rd_we;
  logic [s_burst-1:0]    wr_beat;
  logic [s_burst-1:0]    rd_beat_unused;
  logic [s_line-1:0]     wr_line_unused;

  assign last_beat    = (beat == bw'(nbeats - 1));
  assign aligned_addr = {address_i[31:s_offset], {s_offset{1'b0}}};
  assign wr_load      = (state == IDLE) && write_i;
  assign rd_we        = (state == RD_BURST) && resp_i;

  // Separate read and write buffers so a writeback never disturbs the last fill on line_o.
  cla_line_buffer #(.s_line(s_line), .s_burst(s_burst)) rd_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .line_in  ('0),
    .beat_we  (rd_we),
    .beat_idx (beat),
    .beat_in  (burst_i),
    .line     (line_o),
    .beat_out (rd_beat_unused)
  );

  cla_line_buffer #(.s_line(s_line), .s_burst(s_burst)) wr_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (wr_load),
    .line_in  (line_i),
    .beat_we  (1'b0),
    .beat_idx (beat),
    .beat_in  ('0),
    .line     (wr_line_unused),
    .beat_out (wr_beat)
  );

  assign burst_o = (state == WR_BURST) ? wr_beat : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
`ifdef CLA_PERF_CNT_EN
      rd_lines_o <= '0;
      wr_lines_o <= '0;
`endif
    end else begin
      resp_o <= 1'b0;
      case (state)
        IDLE: begin
          if (write_i) begin
            address_o <= aligned_addr;
            beat      <= '0;
            write_o   <= 1'b1;
            state     <= WR_BURST;
          end else if (read_i) begin
            address_o <= aligned_addr;
            beat      <= '0;
            read_o    <= 1'b1;
            state     <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            if (last_beat) begin
              beat   <= '0;
              read_o <= 1'b0;
              resp_o <= 1'b1;
              state  <= RD_DONE;
`ifdef CLA_PERF_CNT_EN
              rd_lines_o <= rd_lines_o + 32'd1;
`endif
            end else begin
              beat <= beat + bw'(1);
            end
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            if (last_beat) begin
              beat    <= '0;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              state   <= WR_DONE;
`ifdef CLA_PERF_CNT_EN
              wr_lines_o <= wr_lines_o + 32'd1;
`endif
            end else begin
              beat <= beat + bw'(1);
            end
          end
        end
        RD_DONE: state <= IDLE;
        WR_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
